// File: rtl/dmem_arbiter.sv
// Arbitrates the data-memory port between scalar single-word accesses and vector bursts.
// Optional VEC_PREEMPT_EN lets a pending scalar access interrupt a burst between beats.
module dmem_arbiter #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_ready,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             vec_req,
  input  logic             vec_we,
  input  logic [31:0]      vec_base,
  input  logic [LEN_W-1:0] vec_len,
  input  logic [31:0]      vec_wdata,
  output logic             vec_wnext,
  output logic             vec_rvalid,
  output logic [31:0]      vec_rdata,
  output logic             vec_done,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready
);

  typedef enum logic [1:0] {IDLE, CPU, VEC} state_t;

  state_t           state, state_d;
  logic             last_grant;
  logic             vec_we_q;
  logic [31:0]      base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             done_pend;
  logic             grant_vec;
  logic             beat_vec;
  logic             cpu_done;
  logic             last_beat;
  logic             vec_ok;
  logic             len_zero;
`ifdef VEC_PREEMPT_EN
  logic             resume;
  logic             preempt;
`endif

  assign last_beat = (cnt == len_q - LEN_W'(1));
  assign len_zero  = (vec_len == '0);
  // A zero-length burst reports done from IDLE; block a re-grant while that pulse is out.
  assign vec_ok    = vec_req & ~done_pend;
  assign cpu_stall = cpu_req & ~cpu_ready;

  always_comb begin
    state_d    = state;
    grant_vec  = 1'b0;
    beat_vec   = 1'b0;
    cpu_done   = 1'b0;
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    vec_wnext  = 1'b0;
    vec_rvalid = 1'b0;
    vec_rdata  = '0;
    vec_done   = done_pend;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
`ifdef VEC_PREEMPT_EN
    preempt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cpu_req && (!vec_ok || last_grant)) begin
          state_d = CPU;
        end else if (vec_ok) begin
          grant_vec = 1'b1;
          if (!len_zero) state_d = VEC;
        end
      end
      CPU: begin
        mem_req   = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (mem_ready) begin
          cpu_ready = 1'b1;
          cpu_rdata = mem_rdata;
          cpu_done  = 1'b1;
`ifdef VEC_PREEMPT_EN
          state_d   = resume ? VEC : IDLE;
`else
          state_d   = IDLE;
`endif
        end
      end
      VEC: begin
        mem_req   = 1'b1;
        mem_we    = vec_we_q;
        mem_addr  = base_q + (32'(cnt) << 2);
        mem_wdata = vec_wdata;
        if (mem_ready) begin
          beat_vec   = 1'b1;
          vec_wnext  = vec_we_q;
          vec_rvalid = ~vec_we_q;
          vec_rdata  = vec_we_q ? '0 : mem_rdata;
          if (last_beat) begin
            vec_done = 1'b1;
            state_d  = IDLE;
          end
`ifdef VEC_PREEMPT_EN
          else if (cpu_req) begin
            preempt = 1'b1;
            state_d = CPU;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      done_pend  <= 1'b0;
    end else begin
      state     <= state_d;
      done_pend <= grant_vec & len_zero;
      if (grant_vec)     cnt <= '0;
      else if (beat_vec) cnt <= cnt + LEN_W'(1);
      if (cpu_done) last_grant <= 1'b0;
      if ((grant_vec && len_zero) || (beat_vec && last_beat)) last_grant <= 1'b1;
    end
  end

`ifdef VEC_PREEMPT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        resume <= 1'b0;
    else if (preempt)  resume <= 1'b1;
    else if (cpu_done) resume <= 1'b0;
  end
`endif

  // Burst descriptor is plain data: captured at grant, never reset.
  always_ff @(posedge clk) begin
    if (grant_vec) begin
      vec_we_q <= vec_we;
      base_q   <= vec_base;
      len_q    <= vec_len;
    end
  end

endmodule
